serial_frame_tx: RTL

//  Parallel-in/serial-out frame transmitter; transmit-side counterpart of the 8-bit shift register's

---
 rtl/serial_frame_tx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//   Parallel-in / serial-out frame transmitter. A word is accepted through a
//   valid/ready handshake. The frame is a start bit (0), then DATA_W data bits
//   LSB first, then an optional even-parity bit, then a stop bit (1). Each bit
//   is held on the line for CLKS_PER_BIT clocks. The line idles high.
//
// Parameters
//   DATA_W        data bits per frame (>= 1)
//   CLKS_PER_BIT  clocks each bit is held on sout (>= 1)
//
// Ports
//   clk      in   1       clock; all state updates on posedge
//   rst      in   1       asynchronous, active-high reset
//   data_in  in   DATA_W  word to send; sampled only on accept
//   load     in   1       valid: request to send data_in
//   ready    out  1       high only while idle; accept = load & ready
//   sout     out  1       registered serial line, idle high
//   busy     out  1       high from the cycle after accept until the frame ends
//   done     out  1       one-cycle pulse in the cycle after the stop bit ends
//
// Build option
//   SERIAL_FRAME_TX_PARITY_EN  defined: an even-parity bit is sent between the
//                              last data bit and the stop bit.
// -----------------------------------------------------------------------------
module serial_frame_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              sout,
   output logic              busy,
   output logic              done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_W + 1);

   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   // Explicit encoding so that the unused codes fall into the default branch
   // and recover to idle.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t            state_q,   state_d;
   logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shreg_q,   shreg_d;
   logic              sout_q,    sout_d;
   logic              done_q,    done_d;
   logic              bit_end;

`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic              par_q,     par_d;

   // Even parity: the transmitted bit makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_W-1:0] w);
      return ^w;
   endfunction
`endif

   assign bit_end = (clk_cnt_q == CLK_LAST);

   // Next-state, counters and next line value
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      done_d    = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_d     = par_q;
`endif

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (load) begin
               shreg_d = data_in;
`ifdef SERIAL_FRAME_TX_PARITY_EN
               par_d   = even_parity(data_in);
`endif
               state_d = S_START;
            end
         end

         S_START: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               shreg_d   = shreg_q >> 1;
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  state_d   = S_PARITY;
`else
                  state_d   = S_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

`ifdef SERIAL_FRAME_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
`endif

         S_STOP: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = S_IDLE;
               done_d    = 1'b1;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
         end
      endcase

      // The line is registered, so it is driven from the state being entered:
      // the start bit appears on the same edge that accepts the word.
      sout_d = 1'b1;
      case (state_d)
         S_START:  sout_d = 1'b0;
         S_DATA:   sout_d = shreg_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
         S_PARITY: sout_d = par_d;
`endif
         default:  sout_d = 1'b1;
      endcase
   end

   // Control state: cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         sout_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         sout_q    <= sout_d;
         done_q    <= done_d;
      end
   end

   // Datapath: only read while a frame is active, so no reset needed
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = (state_q != S_IDLE);
   assign sout  = sout_q;
   assign done  = done_q;

endmodule
